updn_counter_lim: RTL and testbench
===================================

# updn_counter_lim

Parametrised successor to the 8-bit up/down counter. It adds configurable width and step size, run-time lower and upper limits, and a selectable saturate or wrap mode at those limits. It also provides registered overflow/underflow pulses, at-limit status and limit-configuration error reporting. It is used wherever a bounded event, credit or address counter with programmable range is needed.

## Interface
- WIDTH, 8: counter and limit width in bits (>= 2).
- STEP_W, 4: width of the step-size input (1 .. WIDTH).
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- cen  input  1  count enable.
- load  input  1  active-high synchronous load.
- up_dn  input  1  direction: 1 = up, 0 = down.
- wrap_en  input  1  1 = wrap at limits, 0 = saturate at limits.
- step  input  STEP_W  unsigned increment/decrement per enabled cycle.
- lo_lim  input  WIDTH  lower limit, unsigned, inclusive.
- hi_lim  input  WIDTH  upper limit, unsigned, inclusive.
- data  input  WIDTH  load value.
- count  output  WIDTH  registered counter value.
- at_max  output  1  registered: count == hi_lim.
- at_min  output  1  registered: count == lo_lim.
- ovf  output  1  one-cycle registered pulse: upward step crossed hi_lim.
- unf  output  1  one-cycle registered pulse: downward step crossed lo_lim.
- lim_err  output  1  registered: lo_lim > hi_lim.

## Operation
- Priority per edge: reset > load > count (cen) > hold.
- Reset: count = 0. at_max, at_min, ovf, unf and lim_err are all 0. Flags stay 0 until the first non-reset edge.
- lim_err is updated every non-reset edge to (lo_lim > hi_lim).
- When lo_lim > hi_lim:
  - counting is frozen; cen is ignored and count holds.
  - load writes data unclamped.
  - ovf and unf stay 0.
- Load with valid limits: count = data clamped to [lo_lim, hi_lim] (data > hi_lim gives hi_lim; data < lo_lim gives lo_lim). No ovf/unf on load.
- Count up (cen=1, load=0):
  - sum = count + step, computed at WIDTH+1 bits (no truncation).
  - If sum <= hi_lim, count = sum.
  - Otherwise ovf pulses and count = hi_lim (wrap_en=0) or lo_lim (wrap_en=1). The residual of the step is discarded.
- Count down:
  - If count >= step and count - step >= lo_lim, count = count - step.
  - Otherwise unf pulses and count = lo_lim (wrap_en=0) or hi_lim (wrap_en=1).
- Saturation is not sticky: ovf/unf pulse on every enabled cycle in which the limit rule applies, including when count already equals the limit.
- step = 0 with cen=1: count holds, no ovf/unf.
- Count outside the range (after limits changed): the same arithmetic rules apply.
  - Up from above hi_lim gives ovf.
  - Down from below lo_lim gives unf.
  - Moving toward the range uses plain arithmetic, even if the result is still outside.
- cen=0, load=0: count holds.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Latency is one cycle. An input sampled on edge N is reflected in count and all flags after edge N.
- at_max/at_min compare the newly written count against lo_lim/hi_lim sampled at that same edge. They are refreshed on every non-reset edge, including hold cycles.
- ovf/unf are high for exactly the cycle following the causing edge, and 0 otherwise.
- Reset mid-count overrides load and cen in the same cycle. Counting resumes from 0 on the first edge with rst_n=1.
- Limits, step, wrap_en and up_dn may change on any cycle and take effect at the next edge.

## Test plan
- Reset: count at 0x55, hold rst_n=0 with load=1 and cen=1 for 2 edges -> count=0x00; at_max, at_min, ovf, unf, lim_err all 0.
- Saturate up: lo=10, hi=200, wrap_en=0, load 198, then step=3 up for 3 cycles:
  - count 198 -> 200 with ovf=1 and at_max=1.
  - next cycle: count 200, ovf=1 again.
  - cen=0: count holds at 200, ovf=0.
- Wrap down: lo=10, hi=200, wrap_en=1, load 12, step=5 down:
  - count -> 200 with unf=1, at_max=1.
  - next cycle: count 195, unf=0.
- Load clamp and priority:
  - hi=200: load data=250 with cen=1 -> count=200, no ovf.
  - lo=10: load data=3 -> count=10, at_min=1.
  - step=0, cen=1 -> count holds at 10.
- Limit error: lo=100, hi=50 -> lim_err=1 next cycle.
  - cen=1 up, step=1 -> count frozen.
  - load data=7 -> count=7, unclamped.
  - restore lo=0 -> lim_err=0; counting resumes.
- Out-of-range after limit change: count=150, set hi=100, lo=10, wrap_en=0:
  - step=4 up -> count=100, ovf=1.
  - reload 150, then step=4 down -> count=146, no unf.

Source files
------------

// File: rtl/updn_counter_lim_if.sv
// rtl/updn_counter_lim_if.sv - control/limit inputs and status outputs of the limited up/down counter
interface updn_counter_lim_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              cen;
  logic              load;
  logic              up_dn;
  logic              wrap_en;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  lo_lim;
  logic [WIDTH-1:0]  hi_lim;
  logic [WIDTH-1:0]  data;
  logic [WIDTH-1:0]  count;
  logic              at_max;
  logic              at_min;
  logic              ovf;
  logic              unf;
  logic              lim_err;

  modport master (
    output cen, load, up_dn, wrap_en, step, lo_lim, hi_lim, data,
    input  count, at_max, at_min, ovf, unf, lim_err
  );

  modport slave (
    input  cen, load, up_dn, wrap_en, step, lo_lim, hi_lim, data,
    output count, at_max, at_min, ovf, unf, lim_err
  );
endinterface

// File: rtl/updn_counter_lim.sv
// rtl/updn_counter_lim.sv - up/down counter with programmable limits, step, saturate/wrap and flags
module updn_counter_lim #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  updn_counter_lim_if.slave  bus
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             at_max_q, at_max_d;
  logic             at_min_q, at_min_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             lim_err_q, lim_err_d;

  logic             lim_bad;
  logic [WIDTH:0]   step_x;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  // One extra bit so neither the sum nor the borrow is lost before comparing to the limits
  assign step_x  = (WIDTH+1)'(bus.step);
  assign sum     = {1'b0, count_q} + step_x;
  assign diff    = {1'b0, count_q} - step_x;
  assign lim_bad = bus.lo_lim > bus.hi_lim;

  always_comb begin
    count_d   = count_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    lim_err_d = lim_bad;
    if (bus.load) begin
      if (lim_bad)                   count_d = bus.data;
      else if (bus.data > bus.hi_lim) count_d = bus.hi_lim;
      else if (bus.data < bus.lo_lim) count_d = bus.lo_lim;
      else                           count_d = bus.data;
    end else if (bus.cen && !lim_bad && (bus.step != '0)) begin
      if (bus.up_dn) begin
        if (sum <= {1'b0, bus.hi_lim}) begin
          count_d = sum[WIDTH-1:0];
        end else begin
          ovf_d   = 1'b1;
          count_d = bus.wrap_en ? bus.lo_lim : bus.hi_lim;
        end
      end else begin
        if (({1'b0, count_q} >= step_x) && (diff >= {1'b0, bus.lo_lim})) begin
          count_d = diff[WIDTH-1:0];
        end else begin
          unf_d   = 1'b1;
          count_d = bus.wrap_en ? bus.hi_lim : bus.lo_lim;
        end
      end
    end
    at_max_d = (count_d == bus.hi_lim);
    at_min_d = (count_d == bus.lo_lim);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= '0;
      at_max_q  <= 1'b0;
      at_min_q  <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      lim_err_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      at_max_q  <= at_max_d;
      at_min_q  <= at_min_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      lim_err_q <= lim_err_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.at_max  = at_max_q;
  assign bus.at_min  = at_min_q;
  assign bus.ovf     = ovf_q;
  assign bus.unf     = unf_q;
  assign bus.lim_err = lim_err_q;

endmodule

// File: tb/tb_updn_counter_lim.sv
// tb/tb_updn_counter_lim.sv - directed vectors with per-cycle model compare for updn_counter_lim
module tb_updn_counter_lim;
  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  updn_counter_lim_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  updn_counter_lim #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference behaviour in plain integers
  int m_count, m_max, m_min, m_ovf, m_unf, m_err;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    int lo, hi, st, c;
    lo = int'(bus.lo_lim);
    hi = int'(bus.hi_lim);
    st = int'(bus.step);
    c  = m_count;
    if (!rst_n) begin
      m_count = 0; m_max = 0; m_min = 0; m_ovf = 0; m_unf = 0; m_err = 0;
      m_valid = 1'b1;
    end else begin
      m_err = (lo > hi) ? 1 : 0;
      m_ovf = 0;
      m_unf = 0;
      if (bus.load) begin
        c = int'(bus.data);
        if (m_err == 0) begin
          if (c > hi) c = hi;
          if (c < lo) c = lo;
        end
      end else if (bus.cen && m_err == 0 && st != 0) begin
        if (bus.up_dn) begin
          if (c + st <= hi) c = c + st;
          else begin m_ovf = 1; c = bus.wrap_en ? lo : hi; end
        end else begin
          if (c - st >= lo) c = c - st;
          else begin m_unf = 1; c = bus.wrap_en ? hi : lo; end
        end
      end
      m_count = c;
      m_max = (c == hi) ? 1 : 0;
      m_min = (c == lo) ? 1 : 0;
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      cmp("model_count",   int'(bus.count),   m_count);
      cmp("model_at_max",  int'(bus.at_max),  m_max);
      cmp("model_at_min",  int'(bus.at_min),  m_min);
      cmp("model_ovf",     int'(bus.ovf),     m_ovf);
      cmp("model_unf",     int'(bus.unf),     m_unf);
      cmp("model_lim_err", int'(bus.lim_err), m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drv(input bit cen, input bit load, input bit up, input bit wrap,
                     input int step, input int lo, input int hi, input int data);
    bus.cen     = cen;
    bus.load    = load;
    bus.up_dn   = up;
    bus.wrap_en = wrap;
    bus.step    = STEP_W'(step);
    bus.lo_lim  = WIDTH'(lo);
    bus.hi_lim  = WIDTH'(hi);
    bus.data    = WIDTH'(data);
  endtask

  initial begin
    drv(0, 0, 1, 0, 0, 0, 255, 0);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset with load and cen active
    drv(0, 1, 1, 0, 1, 0, 255, 8'h55); tick();
    cmp("preload_55", int'(bus.count), 8'h55);
    rst_n = 1'b0;
    drv(1, 1, 1, 0, 1, 0, 255, 8'h55); tick(); tick();
    cmp("rst_count", int'(bus.count), 0);
    cmp("rst_flags", int'({bus.at_max, bus.at_min, bus.ovf, bus.unf, bus.lim_err}), 0);
    rst_n = 1'b1;

    // Saturate up
    drv(0, 1, 1, 0, 3, 10, 200, 198); tick();
    drv(1, 0, 1, 0, 3, 10, 200, 0); tick();
    cmp("sat_up_count", int'(bus.count), 200);
    cmp("sat_up_ovf", int'(bus.ovf), 1);
    cmp("sat_up_at_max", int'(bus.at_max), 1);
    tick();
    cmp("sat_up_again_ovf", int'(bus.ovf), 1);
    drv(0, 0, 1, 0, 3, 10, 200, 0); tick();
    cmp("sat_hold_count", int'(bus.count), 200);
    cmp("sat_hold_ovf", int'(bus.ovf), 0);

    // Wrap down
    drv(0, 1, 0, 1, 5, 10, 200, 12); tick();
    drv(1, 0, 0, 1, 5, 10, 200, 0); tick();
    cmp("wrap_dn_count", int'(bus.count), 200);
    cmp("wrap_dn_unf", int'(bus.unf), 1);
    tick();
    cmp("wrap_dn_next", int'(bus.count), 195);
    cmp("wrap_dn_next_unf", int'(bus.unf), 0);

    // Wrap up lands on lo_lim
    drv(0, 1, 1, 1, 3, 10, 200, 199); tick();
    drv(1, 0, 1, 1, 3, 10, 200, 0); tick();
    cmp("wrap_up_count", int'(bus.count), 10);
    cmp("wrap_up_at_min", int'(bus.at_min), 1);

    // Load clamp and priority
    drv(1, 1, 1, 0, 3, 10, 200, 250); tick();
    cmp("clamp_hi", int'(bus.count), 200);
    cmp("clamp_hi_ovf", int'(bus.ovf), 0);
    drv(0, 1, 1, 0, 3, 10, 200, 3); tick();
    cmp("clamp_lo", int'(bus.count), 10);
    cmp("clamp_lo_at_min", int'(bus.at_min), 1);
    drv(1, 0, 0, 0, 0, 10, 200, 0); tick();
    cmp("step0_hold", int'(bus.count), 10);
    cmp("step0_unf", int'(bus.unf), 0);

    // Limit error freezes counting; load unclamped
    drv(0, 0, 1, 0, 1, 100, 50, 0); tick();
    cmp("lim_err_set", int'(bus.lim_err), 1);
    drv(1, 0, 1, 0, 1, 100, 50, 0); tick();
    cmp("lim_err_frozen", int'(bus.count), 10);
    cmp("lim_err_no_ovf", int'(bus.ovf), 0);
    drv(0, 1, 1, 0, 1, 100, 50, 7); tick();
    cmp("lim_err_load", int'(bus.count), 7);
    drv(1, 0, 1, 0, 1, 0, 50, 0); tick();
    cmp("lim_err_clear", int'(bus.lim_err), 0);
    cmp("lim_err_resume", int'(bus.count), 8);

    // Out of range after limit change
    drv(0, 1, 1, 0, 4, 0, 255, 150); tick();
    drv(1, 0, 1, 0, 4, 10, 100, 0); tick();
    cmp("oor_up_count", int'(bus.count), 100);
    cmp("oor_up_ovf", int'(bus.ovf), 1);
    drv(0, 1, 1, 0, 4, 0, 255, 150); tick();
    drv(1, 0, 0, 0, 4, 10, 100, 0); tick();
    cmp("oor_dn_count", int'(bus.count), 146);
    cmp("oor_dn_unf", int'(bus.unf), 0);

    // Down from below lo_lim saturates with unf
    drv(0, 1, 1, 0, 1, 0, 255, 20); tick();
    drv(1, 0, 0, 0, 1, 50, 255, 0); tick();
    cmp("below_lo_count", int'(bus.count), 50);
    cmp("below_lo_unf", int'(bus.unf), 1);

    // Reset mid-count, then resume from 0
    rst_n = 1'b0;
    drv(1, 0, 1, 0, 2, 0, 255, 0); tick();
    rst_n = 1'b1; tick();
    cmp("resume_after_rst", int'(bus.count), 2);

    drv(0, 0, 1, 0, 0, 0, 255, 0); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
